// File: rtl/sng.sv
// Stochastic number generator: compares a latched operand against rand_in once per cycle,
// emitting a FRAME_LEN-bit unipolar stream. Define SNG_ONES_COUNT_EN to add a ones-count output.
module sng #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rand_in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_last,
  output logic             busy
`ifdef SNG_ONES_COUNT_EN
  ,
  output logic [15:0]      ones_count,
  output logic             count_valid
`endif
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [15:0] LastIdx = 16'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_last_q, frame_last_d;
  logic             hit;
  logic             last;

  assign hit  = value_q > rand_in;
  assign last = bit_cnt_q == LastIdx;

`ifdef SNG_ONES_COUNT_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] ones_count_q, ones_count_d;
  logic        count_valid_q, count_valid_d;
`endif

  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    bit_cnt_d    = bit_cnt_q;
    bit_out_d    = 1'b0;
    bit_valid_d  = 1'b0;
    frame_last_d = 1'b0;
`ifdef SNG_ONES_COUNT_EN
    acc_d         = acc_q;
    ones_count_d  = ones_count_q;
    count_valid_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StRun;
          value_d   = in_value;
          bit_cnt_d = '0;
`ifdef SNG_ONES_COUNT_EN
          acc_d = '0;
`endif
        end
      end
      StRun: begin
        bit_out_d    = hit;
        bit_valid_d  = 1'b1;
        bit_cnt_d    = bit_cnt_q + 16'd1;
        frame_last_d = last;
`ifdef SNG_ONES_COUNT_EN
        acc_d = acc_q + 16'(hit);
        if (last) begin
          // Total includes the bit being registered on this edge.
          ones_count_d  = acc_q + 16'(hit);
          count_valid_d = 1'b1;
        end
`endif
        if (last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      value_q      <= '0;
      bit_cnt_q    <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_last_q <= 1'b0;
`ifdef SNG_ONES_COUNT_EN
      acc_q         <= '0;
      ones_count_q  <= '0;
      count_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      frame_last_q <= frame_last_d;
`ifdef SNG_ONES_COUNT_EN
      acc_q         <= acc_d;
      ones_count_q  <= ones_count_d;
      count_valid_q <= count_valid_d;
`endif
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q == StRun);
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign frame_last = frame_last_q;
`ifdef SNG_ONES_COUNT_EN
  assign ones_count  = ones_count_q;
  assign count_valid = count_valid_q;
`endif

endmodule

// File: tb/tb_sng.sv
// Self-checking bench for sng: directed and randomized frames checked against a
// frame-level reference model (expected bit = operand > random word).
module tb_sng;
  localparam int unsigned W  = 8;
  localparam int unsigned FL = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] rand_in = '0;
  logic [W-1:0] in_value = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, bit_out, bit_valid, frame_last, busy;
  logic         cv_obs;
  logic [15:0]  oc_obs;
  logic [5:0]   obs6;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

`ifdef SNG_ONES_COUNT_EN
  localparam bit HasCnt = 1'b1;
  logic [15:0] ones_count;
  logic        count_valid;
  assign cv_obs = count_valid;
  assign oc_obs = ones_count;
`else
  localparam bit HasCnt = 1'b0;
  assign cv_obs = 1'b0;
  assign oc_obs = 16'd0;
`endif

  sng #(
    .WIDTH     (W),
    .FRAME_LEN (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rand_in    (rand_in),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .in_ready   (in_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .frame_last (frame_last),
    .busy       (busy)
`ifdef SNG_ONES_COUNT_EN
    ,
    .ones_count  (ones_count),
    .count_valid (count_valid)
`endif
  );

  always #5 clk = ~clk;

  // {busy, in_ready, bit_valid, bit_out, frame_last, count_valid}
  assign obs6 = {busy, in_ready, bit_valid, bit_out, frame_last, cv_obs};

  localparam logic [5:0] Idle = 6'b010000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: rand ramps 0..FL-1; mode 1: random; mode 2: alternate all-ones / random.
  // hold: keep in_valid high with a new in_value every cycle. abort_at: reset during that bit.
  task automatic run_frame(input logic [W-1:0] value, input int mode, input bit hold,
                           input int abort_at);
    logic [W-1:0] r;
    logic [5:0]   exp;
    bit           exp_bit;
    int           ones;
    check("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = value;
    step();
    check("after_accept", 32'(obs6), 32'(6'b100000));
    ones = 0;
    for (int k = 1; k <= int'(FL); k++) begin
      case (mode)
        0:       r = W'(k - 1);
        1:       r = W'($urandom);
        default: r = (k % 2 == 1) ? {W{1'b1}} : W'($urandom);
      endcase
      rand_in = r;
      if (hold) begin
        in_valid = 1'b1;
        in_value = W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      step();
      exp_bit = value > r;
      ones += int'(exp_bit);
      exp = {k < int'(FL), k == int'(FL), 1'b1, exp_bit, k == int'(FL),
             (k == int'(FL)) && HasCnt};
      check($sformatf("v%0d_bit%0d", value, k), 32'(obs6), 32'(exp));
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1 check("abort_immediate", 32'(obs6), 32'(Idle));
`ifdef SNG_ONES_COUNT_EN
        check("abort_ones_count", 32'(oc_obs), 32'd0);
`endif
        step();
        check("abort_held", 32'(obs6), 32'(Idle));
        rst = 1'b0;
        repeat (3) begin
          step();
          check("abort_released_idle", 32'(obs6), 32'(Idle));
        end
        return;
      end
    end
`ifdef SNG_ONES_COUNT_EN
    check($sformatf("ones_count_v%0d", value), 32'(oc_obs), 32'(ones));
`endif
  endtask

  initial begin
    logic [W-1:0] v;
    #1 rst = 1'b1;
    #1 check("reset_immediate", 32'(obs6), 32'(Idle));
`ifdef SNG_ONES_COUNT_EN
    check("reset_ones_count", 32'(oc_obs), 32'd0);
`endif
    repeat (2) step();
    check("reset_held", 32'(obs6), 32'(Idle));
    rst = 1'b0;
    repeat (3) begin
      step();
      check("idle_after_release", 32'(obs6), 32'(Idle));
    end

    run_frame(8'd0, 0, 1'b0, 0);
    run_frame(8'd100, 0, 1'b0, 0);
    run_frame(8'd255, 0, 1'b0, 0);
    run_frame(8'd255, 2, 1'b0, 0);
    v = W'($urandom);
    run_frame(v, 1, 1'b1, 0);
    v = W'($urandom);
    run_frame(v, 1, 1'b1, 0);
    v = W'($urandom);
    run_frame(v, 1, 1'b0, 0);
    v = W'($urandom);
    run_frame(v, 1, 1'b0, 50);
    run_frame(8'd100, 0, 1'b0, 0);

    in_valid = 1'b0;
    repeat (2) begin
      step();
      check("final_idle", 32'(obs6), 32'(Idle));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
